ch1_sweep_seq: RTL and testbench
================================

Name: ch1_sweep_seq

Overview:
Control sequencer for the channel-1 frequency sweep. Holds the NR10 (FF10) fields and runs the sweep period timer on the 128 Hz frame tick. On each sweep event and on channel trigger it emits one-cycle strobes to the sweep datapath: shifter load, shift clocks, frequency write-back and overflow sampling. Drives the channel-disable level on overflow or negate-mode misuse. Sits directly upstream of the sweep adder/shadow datapath and consumes that datapath's sum-ok flag.

Parameters:
none

Ports:
apu_clk  in  1  APU clock; all state on rising edge
apu_reset  in  1  async active-high reset
d  in  8  CPU data bus
apu_wr  in  1  APU register write strobe, one cycle
ff10  in  1  address decode NR10
ff14  in  1  address decode NR14
sweep_tick  in  1  128 Hz frame-sequencer pulse, one cycle
ch1_sum_ok  in  1  datapath flag, 1 = sum not above 2047 (or subtract mode)
nff10_d3  out  1  inverted NR10 negate bit
ch1_ld_shift  out  1  load shifter from shadow frequency
ch1_shift_clk  out  1  one shift step
ch1_freq_upd1  out  1  write sum bits 10:8 into shadow
ch1_freq_upd2  out  1  write sum bits 7:0 into shadow
ch1_sweep_stop  out  1  level, channel disabled by sweep
sweep_busy  out  1  sequencer not IDLE

Behaviour:
- Single clock, async active-high reset apu_reset. Reset: period=0, negate=0, shift=0, nff10_d3=1, all strobes 0, ch1_sweep_stop=0, sweep_busy=0, timer=0, enable=0, neg_used=0, FSM=IDLE.
- NR10 write (apu_wr&ff10): period<=d[6:4], negate<=d[3], shift<=d[2:0], next edge. If neg_used=1 and d[3]=0: ch1_sweep_stop<=1 the same edge.
- Trigger (apu_wr&ff14&d[7]): timer<=(period==0?8:period); enable<=(period!=0)|(shift!=0); neg_used<=0; ch1_sweep_stop<=0; pass<=TRIG; FSM<=LOAD. Trigger aborts any sequence in progress, including mid-SHIFT; the remaining strobes of the aborted sequence are dropped.
- Timer: 4-bit; on sweep_tick decrements. On the tick where it reaches 0: reload (period==0?8:period). If enable=1 and period!=0 and FSM=IDLE: pass<=EVENT, FSM<=LOAD. A tick while busy still decrements but never starts a second sequence.
- FSM, one state per cycle unless noted:
  IDLE: no strobes.
  LOAD: ch1_ld_shift=1; cnt<=shift. Next state: SHIFT if shift!=0. Otherwise, on TRIG pass, IDLE (no overflow check); on other passes, CHECK.
  SHIFT: ch1_shift_clk=1; cnt decrements; stay until cnt==1, then CHECK. Exactly `shift` pulses are emitted.
  CHECK: sample ch1_sum_ok. If 0, ch1_sweep_stop<=1, enable<=0, then IDLE. Otherwise: if pass=EVENT and shift!=0, go to UPDATE; else IDLE. If negate=1, neg_used<=1.
  UPDATE: ch1_freq_upd1=ch1_freq_upd2=1 in the same cycle; pass<=RECHECK; next LOAD.
  RECHECK pass: performs LOAD/SHIFT/CHECK and never goes to UPDATE.
- Strobes are Moore outputs, registered, glitch-free, mutually exclusive except upd1/upd2. Latency: trigger write edge to ld_shift high = 1 cycle.
- shift uses the NR10 value latched at LOAD. A write to NR10 mid-sequence takes effect from the next LOAD.
- sweep_busy=1 in every state except IDLE.
- Constraint: sweep_tick spacing must be at least 24 clocks. The bench must respect this.
- ch1_sweep_stop is cleared only by trigger or reset.

Test Plan:
- Reset, then NR10=0x00 and trigger -> one ld_shift pulse, no shift_clk, no CHECK sampling, no upd, stop=0, nff10_d3=1.
- NR10=0x12 (period 1, add, shift 2), trigger with ch1_sum_ok=1 -> ld, 2×shift_clk, idle. Next sweep_tick -> ld, 2×shift, CHECK, upd1+upd2 same cycle, ld, 2×shift, CHECK, idle. Total sequence 9 cycles.
- Same config with ch1_sum_ok=0 at trigger CHECK -> ch1_sweep_stop=1 one cycle after CHECK. Subsequent ticks produce no strobes until the next trigger clears stop.
- NR10=0x3B (period 3, negate, shift 3), trigger, then 3 ticks -> one sweep sequence on the 3rd tick only. Then write NR10=0x33 -> stop=1 on the write edge.
- Trigger during 2nd shift_clk of an event -> shifts stop immediately, ld_shift on next cycle, no upd from the aborted pass.
- Assert apu_reset mid-SHIFT -> all outputs reach reset values asynchronously; after release no strobes without a new trigger.

Source files
------------

// File: rtl/ch1_sweep_seq.sv
// Channel-1 frequency sweep sequencer: NR10 register fields, sweep period timer
// and the strobe sequence that drives the sweep adder/shadow datapath.
module ch1_sweep_seq (
    input  logic       apu_clk,
    input  logic       apu_reset,
    input  logic [7:0] d,
    input  logic       apu_wr,
    input  logic       ff10,
    input  logic       ff14,
    input  logic       sweep_tick,
    input  logic       ch1_sum_ok,
    output logic       nff10_d3,
    output logic       ch1_ld_shift,
    output logic       ch1_shift_clk,
    output logic       ch1_freq_upd1,
    output logic       ch1_freq_upd2,
    output logic       ch1_sweep_stop,
    output logic       sweep_busy
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CHECK, UPDATE} state_t;
    typedef enum logic [1:0] {P_TRIG, P_EVENT, P_RECHECK} pass_t;

    state_t     state_q, state_d;
    pass_t      pass_q, pass_d;
    logic [2:0] period_q, period_d;
    logic       nneg_q, nneg_d;
    logic [2:0] shift_q, shift_d;
    logic [2:0] sh_lat_q, sh_lat_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] timer_q, timer_d;
    logic       enable_q, enable_d;
    logic       neg_used_q, neg_used_d;
    logic       stop_q, stop_d;
    logic       ld_q, shclk_q, upd_q, busy_q;

    logic       nr10_wr_s;
    logic       trig_s;
    logic       event_s;
    logic [3:0] reload_s;

    // Next-state logic; trigger is applied last so it overrides any sequence in flight.
    always_comb begin
        state_d    = state_q;
        pass_d     = pass_q;
        period_d   = period_q;
        nneg_d     = nneg_q;
        shift_d    = shift_q;
        sh_lat_d   = sh_lat_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        enable_d   = enable_q;
        neg_used_d = neg_used_q;
        stop_d     = stop_q;
        event_s    = 1'b0;

        nr10_wr_s = apu_wr & ff10;
        trig_s    = apu_wr & ff14 & d[7];
        reload_s  = (period_q == 3'd0) ? 4'd8 : {1'b0, period_q};

        if (sweep_tick) begin
            if (timer_q <= 4'd1) begin
                timer_d = reload_s;
                event_s = enable_q && (period_q != 3'd0);
            end else begin
                timer_d = timer_q - 4'd1;
            end
        end else begin
            timer_d = timer_q;
        end

        case (state_q)
            IDLE: begin
                if (event_s) begin
                    pass_d  = P_EVENT;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                cnt_d    = shift_q;
                sh_lat_d = shift_q;
                if (shift_q != 3'd0) begin
                    state_d = SHIFT;
                end else if (pass_q == P_TRIG) begin
                    state_d = IDLE;
                end else begin
                    state_d = CHECK;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = CHECK;
                end else begin
                    state_d = SHIFT;
                end
            end
            CHECK: begin
                if (!nneg_q) begin
                    neg_used_d = 1'b1;
                end else begin
                    neg_used_d = neg_used_q;
                end
                if (!ch1_sum_ok) begin
                    stop_d   = 1'b1;
                    enable_d = 1'b0;
                    state_d  = IDLE;
                end else if ((pass_q == P_EVENT) && (sh_lat_q != 3'd0)) begin
                    state_d = UPDATE;
                end else begin
                    state_d = IDLE;
                end
            end
            UPDATE: begin
                pass_d  = P_RECHECK;
                state_d = LOAD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clearing negate after it has been used in a calculation kills the channel.
        if (nr10_wr_s) begin
            period_d = d[6:4];
            nneg_d   = ~d[3];
            shift_d  = d[2:0];
            if (neg_used_q && !d[3]) begin
                stop_d = 1'b1;
            end else begin
                stop_d = stop_d;
            end
        end else begin
            period_d = period_d;
        end

        if (trig_s) begin
            timer_d    = reload_s;
            enable_d   = (period_q != 3'd0) || (shift_q != 3'd0);
            neg_used_d = 1'b0;
            stop_d     = 1'b0;
            pass_d     = P_TRIG;
            state_d    = LOAD;
        end else begin
            state_d = state_d;
        end
    end

    // State and strobe registers; strobes are decoded from the next state so they are flop outputs.
    always_ff @(posedge apu_clk or posedge apu_reset) begin
        if (apu_reset) begin
            state_q    <= IDLE;
            pass_q     <= P_TRIG;
            period_q   <= 3'd0;
            nneg_q     <= 1'b1;
            shift_q    <= 3'd0;
            sh_lat_q   <= 3'd0;
            cnt_q      <= 3'd0;
            timer_q    <= 4'd0;
            enable_q   <= 1'b0;
            neg_used_q <= 1'b0;
            stop_q     <= 1'b0;
            ld_q       <= 1'b0;
            shclk_q    <= 1'b0;
            upd_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pass_q     <= pass_d;
            period_q   <= period_d;
            nneg_q     <= nneg_d;
            shift_q    <= shift_d;
            sh_lat_q   <= sh_lat_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            enable_q   <= enable_d;
            neg_used_q <= neg_used_d;
            stop_q     <= stop_d;
            ld_q       <= (state_d == LOAD);
            shclk_q    <= (state_d == SHIFT);
            upd_q      <= (state_d == UPDATE);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign nff10_d3       = nneg_q;
    assign ch1_ld_shift   = ld_q;
    assign ch1_shift_clk  = shclk_q;
    assign ch1_freq_upd1  = upd_q;
    assign ch1_freq_upd2  = upd_q;
    assign ch1_sweep_stop = stop_q;
    assign sweep_busy     = busy_q;

endmodule

// File: tb/tb_ch1_sweep_seq.sv
// Bench for ch1_sweep_seq: a pulse-list model of each sweep pass checked every cycle,
// plus literal pulse counts per scenario.
module tb_ch1_sweep_seq;

    localparam int C_IDLE = 0;
    localparam int C_LD   = 1;
    localparam int C_SH   = 2;
    localparam int C_CHK  = 3;
    localparam int C_UPD  = 4;
    localparam int P_TRIG = 0;
    localparam int P_EVT  = 1;
    localparam int P_RCK  = 2;

    logic       apu_clk = 1'b0;
    logic       apu_reset;
    logic [7:0] d;
    logic       apu_wr, ff10, ff14, sweep_tick, ch1_sum_ok;
    logic       nff10_d3, ch1_ld_shift, ch1_shift_clk, ch1_freq_upd1, ch1_freq_upd2;
    logic       ch1_sweep_stop, sweep_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ld = 0, n_sh = 0, n_upd = 0, n_busy = 0;
    int s_ld, s_sh, s_upd, s_busy;

    // model state
    int sched[$];
    int cur = C_IDLE;
    int m_period = 0, m_shift = 0, m_timer = 0, m_pass = P_TRIG, m_lat = 0;
    bit m_negate = 1'b0, m_en = 1'b0, m_negused = 1'b0, m_stop = 1'b0;

    ch1_sweep_seq dut (
        .apu_clk        (apu_clk),
        .apu_reset      (apu_reset),
        .d              (d),
        .apu_wr         (apu_wr),
        .ff10           (ff10),
        .ff14           (ff14),
        .sweep_tick     (sweep_tick),
        .ch1_sum_ok     (ch1_sum_ok),
        .nff10_d3       (nff10_d3),
        .ch1_ld_shift   (ch1_ld_shift),
        .ch1_shift_clk  (ch1_shift_clk),
        .ch1_freq_upd1  (ch1_freq_upd1),
        .ch1_freq_upd2  (ch1_freq_upd2),
        .ch1_sweep_stop (ch1_sweep_stop),
        .sweep_busy     (sweep_busy)
    );

    always #5 apu_clk = ~apu_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pass(input int sh, input bit with_check);
        sched.push_back(C_LD);
        for (int i = 0; i < sh; i++) sched.push_back(C_SH);
        if (with_check) sched.push_back(C_CHK);
    endtask

    // Model: each pass is a list of per-cycle pulses; CHECK outcome decides what follows.
    always @(posedge apu_clk or posedge apu_reset) begin
        bit nu_old;
        bit fire;
        int old;
        int rl;
        if (apu_reset) begin
            sched.delete();
            cur = C_IDLE; m_period = 0; m_shift = 0; m_timer = 0; m_pass = P_TRIG; m_lat = 0;
            m_negate = 1'b0; m_en = 1'b0; m_negused = 1'b0; m_stop = 1'b0;
        end else begin
            nu_old = m_negused;
            old    = cur;
            fire   = 1'b0;
            rl     = (m_period == 0) ? 8 : m_period;
            if (old == C_CHK) begin
                if (m_negate) m_negused = 1'b1;
                if (!ch1_sum_ok) begin
                    m_stop = 1'b1;
                    m_en   = 1'b0;
                end else if (m_pass == P_EVT && m_lat != 0) begin
                    sched.push_back(C_UPD);
                    m_pass = P_RCK;
                    m_lat  = m_shift;
                    push_pass(m_shift, 1'b1);
                end
            end
            if (sweep_tick) begin
                if (m_timer <= 1) begin
                    m_timer = rl;
                    fire = m_en && (m_period != 0) && (old == C_IDLE);
                end else begin
                    m_timer = m_timer - 1;
                end
            end
            if (fire) begin
                m_pass = P_EVT;
                m_lat  = m_shift;
                push_pass(m_shift, 1'b1);
            end
            if (apu_wr && ff14 && d[7]) begin
                sched.delete();
                m_timer   = rl;
                m_en      = (m_period != 0) || (m_shift != 0);
                m_negused = 1'b0;
                m_stop    = 1'b0;
                m_pass    = P_TRIG;
                m_lat     = m_shift;
                push_pass(m_shift, m_shift != 0);
            end
            if (apu_wr && ff10) begin
                if (nu_old && !d[3]) m_stop = 1'b1;
                m_period = int'(d[6:4]);
                m_negate = d[3];
                m_shift  = int'(d[2:0]);
            end
            cur = (sched.size() > 0) ? sched.pop_front() : C_IDLE;
        end
    end

    // Per-cycle comparison against the model, plus pulse tallies for the literal checks.
    always @(negedge apu_clk) begin
        chk("ld_shift",  int'(ch1_ld_shift),   int'(cur == C_LD));
        chk("shift_clk", int'(ch1_shift_clk),  int'(cur == C_SH));
        chk("freq_upd1", int'(ch1_freq_upd1),  int'(cur == C_UPD));
        chk("freq_upd2", int'(ch1_freq_upd2),  int'(cur == C_UPD));
        chk("busy",      int'(sweep_busy),     int'(cur != C_IDLE));
        chk("stop",      int'(ch1_sweep_stop), int'(m_stop));
        chk("nff10_d3",  int'(nff10_d3),       int'(!m_negate));
        if (ch1_ld_shift)  n_ld++;
        if (ch1_shift_clk) n_sh++;
        if (ch1_freq_upd1) n_upd++;
        if (sweep_busy)    n_busy++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge apu_clk);
    endtask

    task automatic wr(input bit is10, input logic [7:0] v);
        apu_wr = 1'b1; ff10 = is10; ff14 = !is10; d = v;
        @(negedge apu_clk);
        apu_wr = 1'b0; ff10 = 1'b0; ff14 = 1'b0; d = 8'h00;
    endtask

    task automatic tick();
        sweep_tick = 1'b1;
        @(negedge apu_clk);
        sweep_tick = 1'b0;
    endtask

    task automatic snap();
        s_ld = n_ld; s_sh = n_sh; s_upd = n_upd; s_busy = n_busy;
    endtask

    initial begin
        apu_reset = 1'b1; d = 8'h00; apu_wr = 1'b0; ff10 = 1'b0; ff14 = 1'b0;
        sweep_tick = 1'b0; ch1_sum_ok = 1'b1;
        idle(3);
        chk("rst_nff", int'(nff10_d3), 1);
        chk("rst_busy", int'(sweep_busy), 0);
        chk("rst_stop", int'(ch1_sweep_stop), 0);
        apu_reset = 1'b0;
        idle(2);

        // NR10=0: trigger gives a lone load, no overflow sampling
        ch1_sum_ok = 1'b0;
        wr(1'b1, 8'h00);
        snap();
        wr(1'b0, 8'h80);
        idle(6);
        chk("t1_ld", n_ld - s_ld, 1);
        chk("t1_sh", n_sh - s_sh, 0);
        chk("t1_stop", int'(ch1_sweep_stop), 0);
        chk("t1_nff", int'(nff10_d3), 1);
        ch1_sum_ok = 1'b1;

        // NR10=0x12: trigger pass, then a full 9-cycle sweep event
        wr(1'b1, 8'h12);
        snap();
        wr(1'b0, 8'h80);
        idle(8);
        chk("t2_trig_ld", n_ld - s_ld, 1);
        chk("t2_trig_sh", n_sh - s_sh, 2);
        chk("t2_trig_upd", n_upd - s_upd, 0);
        idle(20);
        snap();
        tick();
        idle(14);
        chk("t2_evt_busy", n_busy - s_busy, 9);
        chk("t2_evt_ld", n_ld - s_ld, 2);
        chk("t2_evt_sh", n_sh - s_sh, 4);
        chk("t2_evt_upd", n_upd - s_upd, 1);

        // overflow on trigger check disables the channel
        ch1_sum_ok = 1'b0;
        wr(1'b0, 8'h80);
        idle(8);
        chk("t3_stop", int'(ch1_sweep_stop), 1);
        ch1_sum_ok = 1'b1;
        snap();
        idle(26); tick();
        idle(26); tick();
        idle(10);
        chk("t3_quiet_ld", n_ld - s_ld, 0);
        chk("t3_stop_held", int'(ch1_sweep_stop), 1);

        // NR10=0x3B: event on third tick only; clearing negate then stops
        wr(1'b1, 8'h3B);
        wr(1'b0, 8'h80);
        idle(10);
        chk("t4_nff", int'(nff10_d3), 0);
        snap();
        tick(); idle(26);
        chk("t4_tick1_ld", n_ld - s_ld, 0);
        tick(); idle(26);
        chk("t4_tick2_ld", n_ld - s_ld, 0);
        tick(); idle(20);
        chk("t4_tick3_ld", n_ld - s_ld, 2);
        chk("t4_tick3_upd", n_upd - s_upd, 1);
        wr(1'b1, 8'h33);
        chk("t4_negstop", int'(ch1_sweep_stop), 1);

        // trigger during the second shift of an event aborts it
        wr(1'b1, 8'h12);
        wr(1'b0, 8'h80);
        idle(10);
        chk("t5_cleared", int'(ch1_sweep_stop), 0);
        idle(20);
        snap();
        tick();
        idle(2);
        wr(1'b0, 8'h80);
        idle(12);
        chk("t5_ld", n_ld - s_ld, 2);
        chk("t5_sh", n_sh - s_sh, 4);
        chk("t5_upd", n_upd - s_upd, 0);

        // async reset in the middle of a shift
        idle(30);
        tick();
        @(negedge apu_clk);
        #2 apu_reset = 1'b1;
        #1;
        chk("t6_ld", int'(ch1_ld_shift), 0);
        chk("t6_sh", int'(ch1_shift_clk), 0);
        chk("t6_busy", int'(sweep_busy), 0);
        chk("t6_stop", int'(ch1_sweep_stop), 0);
        chk("t6_nff", int'(nff10_d3), 1);
        @(negedge apu_clk);
        apu_reset = 1'b0;
        snap();
        idle(26); tick();
        idle(30);
        chk("t6_quiet_ld", n_ld - s_ld, 0);
        chk("t6_quiet_sh", n_sh - s_sh, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
